// File: rtl/effect_chain_if.sv
// Sequencer-to-effect-slot bus: shared sample bus, per-slot enable/grant, per-slot done and result.
// The sequencer connects through the master modport and the effect blocks through the slave modport.
interface effect_chain_if #(
  parameter int DATA_WIDTH  = 16,
  parameter int NUM_EFFECTS = 4
);
  logic [NUM_EFFECTS-1:0]            effect_cs;
  logic [NUM_EFFECTS-1:0]            effect_my_turn;
  logic [DATA_WIDTH-1:0]             effect_data_in;
  logic [NUM_EFFECTS-1:0]            effect_done;
  logic [NUM_EFFECTS*DATA_WIDTH-1:0] effect_data_out;

  modport master (
    output effect_cs, effect_my_turn, effect_data_in,
    input  effect_done, effect_data_out
  );

  modport slave (
    input  effect_cs, effect_my_turn, effect_data_in,
    output effect_done, effect_data_out
  );
endinterface

// File: rtl/effect_chain_sequencer.sv
// Runs each accepted audio sample serially through the enabled effect slots and emits the result.
// Optional per-slot watchdog: define EFFECT_WATCHDOG_EN.
module effect_chain_sequencer #(
  parameter int DATA_WIDTH     = 16,
  parameter int NUM_EFFECTS    = 4,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   sample_valid,
  input  logic [DATA_WIDTH-1:0]  sample_in,
  input  logic [NUM_EFFECTS-1:0] bypass_mask,
  input  logic                   overrun_clr,
  effect_chain_if.master         fx,
  output logic [DATA_WIDTH-1:0]  sample_out,
  output logic                   sample_out_valid,
  output logic                   busy,
  output logic                   overrun,
  output logic                   timeout
);

  localparam int IDX_W = (NUM_EFFECTS > 1) ? $clog2(NUM_EFFECTS) : 1;

  if (NUM_EFFECTS < 1 || NUM_EFFECTS > 8 || TIMEOUT_CYCLES < 1) begin : g_bad_config
    $error("effect_chain_sequencer: unsupported parameter configuration");
  end

  typedef enum logic [1:0] {IDLE, STEP, WAIT, FINISH} state_t;

  state_t                 state, state_nxt;
  logic [IDX_W-1:0]       idx;
  logic [DATA_WIDTH-1:0]  working;
  logic [NUM_EFFECTS-1:0] mask;
  logic                   last_slot;
  logic                   wd_fire;
  logic                   slot_finished;

  assign last_slot     = (idx == IDX_W'(NUM_EFFECTS - 1));
  // A watchdog expiry advances the chain exactly like a done, but leaves working untouched.
  assign slot_finished = fx.effect_done[idx] | wd_fire;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // NOTE: always_comb assigns a default first so no path leaves state_nxt unassigned (no latch).
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:   if (sample_valid) state_nxt = STEP;
      STEP:   if (!mask[idx])   state_nxt = WAIT;
              else if (last_slot) state_nxt = FINISH;
      WAIT:   if (slot_finished) state_nxt = last_slot ? FINISH : STEP;
      FINISH: state_nxt = IDLE;
    endcase
  end

  // NOTE: there is no memory here, so every register is cleared by reset, including the datapath.
  always_ff @(posedge clk) begin
    if (!rst) begin
      idx                <= '0;
      working            <= '0;
      mask               <= '0;
      sample_out         <= '0;
      sample_out_valid   <= 1'b0;
      busy               <= 1'b0;
      overrun            <= 1'b0;
      fx.effect_cs       <= '0;
      fx.effect_my_turn  <= '0;
      fx.effect_data_in  <= '0;
    end else begin
      sample_out_valid <= 1'b0;
      busy             <= (state_nxt != IDLE);
      // A fresh drop in the same cycle as a clear must still be reported.
      if (sample_valid && state != IDLE) overrun <= 1'b1;
      else if (overrun_clr)              overrun <= 1'b0;

      case (state)
        IDLE: begin
          if (sample_valid) begin
            working      <= sample_in;
            mask         <= bypass_mask;
            fx.effect_cs <= ~bypass_mask;
            idx          <= '0;
          end
        end
        STEP: begin
          if (mask[idx]) begin
            if (!last_slot) idx <= idx + 1'b1;
          end else begin
            fx.effect_data_in <= working;
            fx.effect_my_turn <= NUM_EFFECTS'(1) << idx;
          end
        end
        WAIT: begin
          if (slot_finished) begin
            // Grant drops on the done edge so the slot cannot restart when it goes passive.
            fx.effect_my_turn <= '0;
            if (fx.effect_done[idx]) working <= fx.effect_data_out[idx*DATA_WIDTH +: DATA_WIDTH];
            if (!last_slot) idx <= idx + 1'b1;
          end
        end
        FINISH: begin
          sample_out       <= working;
          sample_out_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef EFFECT_WATCHDOG_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [WD_W-1:0] wd_cnt;

  assign wd_fire = (state == WAIT) && !fx.effect_done[idx] &&
                   (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (!rst) begin
      wd_cnt  <= '0;
      timeout <= 1'b0;
    end else begin
      if (state == STEP)      wd_cnt <= '0;
      else if (state == WAIT) wd_cnt <= wd_cnt + 1'b1;
      if (wd_fire) timeout <= 1'b1;
    end
  end
`else
  assign wd_fire = 1'b0;
  assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_effect_chain_sequencer.sv
// Scoreboard bench for effect_chain_sequencer: directed samples, bench-side effect slot models.
// Define EFFECT_WATCHDOG_EN to also exercise the slot watchdog with TIMEOUT_CYCLES=16.
`timescale 1ns/1ps
module tb_effect_chain_sequencer;

  localparam int DW = 16;
  localparam int NE = 4;
`ifdef EFFECT_WATCHDOG_EN
  localparam int TO = 16;
`else
  localparam int TO = 4096;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          sample_valid = 1'b0;
  logic          overrun_clr = 1'b0;
  logic [DW-1:0] sample_in = '0;
  logic [NE-1:0] bypass_mask = '0;
  logic [DW-1:0] sample_out;
  logic          sample_out_valid, busy, overrun, timeout;

  effect_chain_if #(.DATA_WIDTH(DW), .NUM_EFFECTS(NE)) fx ();

  effect_chain_sequencer #(.DATA_WIDTH(DW), .NUM_EFFECTS(NE), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .sample_valid(sample_valid), .sample_in(sample_in),
    .bypass_mask(bypass_mask), .overrun_clr(overrun_clr), .fx(fx),
    .sample_out(sample_out), .sample_out_valid(sample_out_valid), .busy(busy),
    .overrun(overrun), .timeout(timeout)
  );

  always #5 clk = ~clk;

  int            errors = 0;
  int            checks = 0;
  logic [DW-1:0] exp_q[$];
  int            grant_log[$];
  int            mode = 0;
  int            hang_slot = -1;
  int            onehot_errs = 0;
  int            turn2_cycles = 0;
  int            cnt[NE];
  logic [NE-1:0] prev_turn = '0;
  logic [NE-1:0] prev_done = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] slot_result(input int i, input logic [DW-1:0] d);
    if (mode == 1 && i == 1) return d + 16'd2;
    if (mode == 1 && i == 3) return -d;
    return d + 16'd1;
  endfunction

  // Effect slot models: done pulses 3 cycles after my_turn rises, result alongside it.
  always @(posedge clk) begin
    for (int i = 0; i < NE; i++) begin
      if (fx.effect_my_turn[i]) begin
        if (cnt[i] == 2 && hang_slot != i) begin
          fx.effect_done[i] <= 1'b1;
          fx.effect_data_out[i*DW +: DW] <= slot_result(i, fx.effect_data_in);
        end else begin
          fx.effect_done[i] <= 1'b0;
        end
        cnt[i] <= cnt[i] + 1;
      end else begin
        cnt[i] <= 0;
        fx.effect_done[i] <= 1'b0;
      end
    end
  end

  // Output monitor: every valid pulse must match the oldest expected sample.
  always @(negedge clk) begin
    if (sample_out_valid) begin
      if (exp_q.size() == 0) check("unexpected_out_pulse", {48'd0, sample_out}, 64'hDEAD_0000_0000);
      else check("sample_out", sample_out, exp_q.pop_front());
    end
  end

  // Grant monitor: order log, one-hot property, grant drop after done.
  always @(negedge clk) begin
    for (int i = 0; i < NE; i++) begin
      if (fx.effect_my_turn[i] && !prev_turn[i]) grant_log.push_back(i);
      if (prev_done[i]) check("turn_low_after_done", fx.effect_my_turn[i], 0);
    end
    if (!$onehot0(fx.effect_my_turn)) onehot_errs++;
    if (fx.effect_my_turn[2]) turn2_cycles++;
    prev_turn = fx.effect_my_turn;
    prev_done = fx.effect_done;
  end

  // Called at a negedge; the sample is taken on the following posedge.
  task automatic send(input logic [DW-1:0] d, input logic [NE-1:0] m);
    sample_valid = 1'b1;
    sample_in    = d;
    bypass_mask  = m;
    @(negedge clk);
    sample_valid = 1'b0;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || busy) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("drain_in_budget", n >= budget, 0);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int lat;
    int n;
    for (int i = 0; i < NE; i++) cnt[i] = 0;
    fx.effect_done     = '0;
    fx.effect_data_out = '0;

    // Reset state
    repeat (3) @(negedge clk);
    check("reset_outputs", {sample_out, sample_out_valid, fx.effect_my_turn, fx.effect_cs,
                            fx.effect_data_in, busy, overrun, timeout}, 0);
    rst = 1'b1;
    @(negedge clk);

    // All slots bypassed: passthrough with T+6 latency, no grants
    grant_log.delete();
    exp_q.push_back(16'h1234);
    send(16'h1234, 4'b1111);
    lat = 1;
    while (!sample_out_valid && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    check("bypass_latency", lat, 6);
    drain(100);
    check("bypass_no_grants", grant_log.size(), 0);
    check("bypass_cs", fx.effect_cs, 4'b0000);

    // All slots enabled, each adds 1
    mode = 0;
    grant_log.delete();
    exp_q.push_back(16'h0014);
    send(16'h0010, 4'b0000);
    drain(200);
    check("all_cs", fx.effect_cs, 4'b1111);
    check("all_grant_count", grant_log.size(), 4);
    for (int i = 0; i < 4 && i < grant_log.size(); i++) check("all_grant_order", grant_log[i], i);

    // Mask 0101: slot1 adds 2, slot3 negates
    mode = 1;
    grant_log.delete();
    exp_q.push_back(16'hFFF9);
    send(16'h0005, 4'b0101);
    @(negedge clk);
    check("mixed_cs", fx.effect_cs, 4'b1010);
    drain(200);
    check("mixed_grant_count", grant_log.size(), 2);
    if (grant_log.size() == 2) begin
      check("mixed_grant_first", grant_log[0], 1);
      check("mixed_grant_second", grant_log[1], 3);
    end
    mode = 0;

    // Overrun: sample while busy is dropped
    check("overrun_idle", overrun, 0);
    exp_q.push_back(16'hAAAA);
    send(16'hAAAA, 4'b1111);
    send(16'hBBBB, 4'b1111);
    check("overrun_set", overrun, 1);
    drain(100);
    check("overrun_sticky", overrun, 1);
    overrun_clr = 1'b1;
    @(negedge clk);
    overrun_clr = 1'b0;
    check("overrun_cleared", overrun, 0);

    // Overrun set beats a simultaneous clear
    exp_q.push_back(16'hCCCC);
    send(16'hCCCC, 4'b1111);
    overrun_clr = 1'b1;
    send(16'h1111, 4'b1111);
    overrun_clr = 1'b0;
    check("overrun_set_wins", overrun, 1);
    drain(100);
    overrun_clr = 1'b1;
    @(negedge clk);
    overrun_clr = 1'b0;

    // Sample arriving in the output-pulse cycle is accepted
    exp_q.push_back(16'hDDDD);
    send(16'hDDDD, 4'b1111);
    n = 0;
    while (!sample_out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("pulse_cycle_wait", n >= 50, 0);
    exp_q.push_back(16'hEEEE);
    send(16'hEEEE, 4'b1111);
    drain(100);
    check("pulse_cycle_no_overrun", overrun, 0);

    // Reset while a slot is granted: abort, no output pulse
    send(16'h0200, 4'b0000);
    n = 0;
    while (fx.effect_my_turn == '0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("reset_reach_wait", n >= 50, 0);
    rst = 1'b0;
    @(negedge clk);
    check("reset_mid_outputs", {sample_out, sample_out_valid, fx.effect_my_turn, fx.effect_cs,
                                fx.effect_data_in, busy, overrun, timeout}, 0);
    rst = 1'b1;
    repeat (30) @(negedge clk);
    exp_q.push_back(16'h0104);
    send(16'h0100, 4'b0000);
    drain(200);

`ifdef EFFECT_WATCHDOG_EN
    // Slot 2 never completes: watchdog bypasses it after 16 cycles
    hang_slot = 2;
    turn2_cycles = 0;
    exp_q.push_back(16'h0003);
    send(16'h0000, 4'b0000);
    drain(300);
    check("wd_timeout_flag", timeout, 1);
    check("wd_turn2_cycles", turn2_cycles, 16);
    hang_slot = -1;
`else
    check("timeout_tied_low", timeout, 0);
`endif

    check("onehot_grant", onehot_errs, 0);
    check("scoreboard_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "bench time limit");
  end

endmodule
